// File: rtl/avsdpll_pkg.sv
// avsdpll_pkg
//   Shared definitions for the PLL lock detector: detector state encoding and
//   default values for the detector parameters.
package avsdpll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  localparam int DEF_MULT       = 8;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/avsdpll_ref_sync.sv
// avsdpll_ref_sync
//   Brings the asynchronous reference clock into the CLK domain and produces a
//   one-cycle pulse for each rising edge of REF.
// Ports:
//   CLK      in   PLL output clock (rising edge)
//   RSTb     in   asynchronous active-low reset
//   REF      in   reference clock, asynchronous to CLK
//   ref_rise out  one-cycle pulse, 2-3 CLK edges after a REF rising edge
module avsdpll_ref_sync (
  input  logic CLK,
  input  logic RSTb,
  input  logic REF,
  output logic ref_rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic dly_reg;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      dly_reg   <= 1'b0;
    end else begin
      sync1_reg <= REF;
      sync2_reg <= sync1_reg;
      dly_reg   <= sync2_reg;
    end
  end

  // Driven only by flops, so the pulse is glitch-free in the CLK domain.
  assign ref_rise = sync2_reg & ~dly_reg;

endmodule

// File: rtl/avsdpll_lock_det.sv
// avsdpll_lock_det
//   PLL lock detector. Counts CLK cycles per REF period and declares lock after
//   LOCK_CNT consecutive periods within TOL of MULT; drops lock after
//   UNLOCK_CNT consecutive bad periods or when REF stops toggling.
// Optional feature: define AVSDPLL_LOCKDET_STICKY_EN to add the sticky
//   loss-of-lock flag (LOL_STICKY output, LOL_CLR input).
// Ports:
//   CLK         in   PLL output clock, all logic on its rising edge
//   RSTb        in   asynchronous active-low reset
//   REF         in   reference clock, asynchronous to CLK
//   EN          in   detector enable; low holds the detector idle
//   LOCK        out  lock indication
//   REF_LOST    out  no REF edge within 2^CNT_W-1 CLK cycles
//   PERIOD_CNT  out  last measured CLK cycles per REF period
//   LOL_STICKY  out  (sticky build) set on any loss of lock
//   LOL_CLR     in   (sticky build) clears LOL_STICKY
module avsdpll_lock_det
  import avsdpll_pkg::*;
#(
  parameter int MULT       = DEF_MULT,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             REF,
  input  logic             EN,
  output logic             LOCK,
  output logic             REF_LOST,
  output logic [CNT_W-1:0] PERIOD_CNT
`ifdef AVSDPLL_LOCKDET_STICKY_EN
  ,
  output logic             LOL_STICKY,
  input  logic             LOL_CLR
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);
  // Acceptance window, clamped at zero so a large TOL cannot wrap.
  localparam int LO_BOUND = (MULT > TOL) ? (MULT - TOL) : 0;
  localparam int HI_BOUND = MULT + TOL;
  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

  logic ref_rise;

  avsdpll_ref_sync u_ref_sync (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .REF     (REF),
    .ref_rise(ref_rise)
  );

  lock_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [GW-1:0]    good_cnt_reg, good_cnt_next;
  logic [BW-1:0]    bad_cnt_reg, bad_cnt_next;
  logic             lock_reg, lock_next;
  logic             ref_lost_reg, ref_lost_next;
  logic [CNT_W-1:0] period_new;
  logic             period_good;
  logic             lock_loss;

  // A rise on the saturation cycle records the saturated value rather than
  // wrapping to zero, so it is judged as a (long) bad period.
  assign period_new  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
  assign period_good = (32'(period_new) >= LO_BOUND) && (32'(period_new) <= HI_BOUND);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      period_reg   <= '0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
      lock_reg     <= 1'b0;
      ref_lost_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      period_reg   <= period_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      lock_reg     <= lock_next;
      ref_lost_reg <= ref_lost_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    period_next   = period_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    lock_next     = lock_reg;
    ref_lost_next = ref_lost_reg;

    if (!EN) begin
      state_next    = IDLE;
      cnt_next      = '0;
      good_cnt_next = '0;
      bad_cnt_next  = '0;
      lock_next     = 1'b0;
      ref_lost_next = 1'b0;
    end else if (ref_rise) begin
      cnt_next      = '0;
      period_next   = period_new;
      ref_lost_next = 1'b0;
      case (state_reg)
        IDLE: state_next = ACQ;   // first period has an unknown start; skip it
        ACQ: begin
          if (!period_good) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg == GW'(LOCK_CNT - 1)) begin
            state_next    = LOCKED;
            good_cnt_next = '0;
            lock_next     = 1'b1;
          end else begin
            good_cnt_next = good_cnt_reg + GW'(1);
          end
        end
        LOCKED: begin
          if (period_good) begin
            bad_cnt_next = '0;
          end else if (bad_cnt_reg == BW'(UNLOCK_CNT - 1)) begin
            state_next   = ACQ;
            bad_cnt_next = '0;
            lock_next    = 1'b0;
          end else begin
            bad_cnt_next = bad_cnt_reg + BW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (cnt_reg == CNT_PRE) begin
      // Saturation edge: REF has gone quiet. cnt then parks at CNT_MAX, so the
      // timeout fires once per outage rather than repeating.
      cnt_next      = CNT_MAX;
      state_next    = IDLE;
      good_cnt_next = '0;
      bad_cnt_next  = '0;
      lock_next     = 1'b0;
      ref_lost_next = 1'b1;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign lock_loss = (state_reg == LOCKED) && (state_next != LOCKED);

`ifdef AVSDPLL_LOCKDET_STICKY_EN
  logic sticky_reg;

  // Set has priority over clear so a loss coinciding with LOL_CLR is kept.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      sticky_reg <= 1'b0;
    end else if (lock_loss) begin
      sticky_reg <= 1'b1;
    end else if (LOL_CLR) begin
      sticky_reg <= 1'b0;
    end
  end

  assign LOL_STICKY = sticky_reg;
`else
  logic unused_lock_loss;
  assign unused_lock_loss = lock_loss;
`endif

  assign LOCK       = lock_reg;
  assign REF_LOST   = ref_lost_reg;
  assign PERIOD_CNT = period_reg;

endmodule

// File: tb/tb_avsdpll_lock_det.sv
// tb_avsdpll_lock_det
//   Directed bench for avsdpll_lock_det. Two instances share stimulus: one with
//   default parameters and one with TOL=1. REF edges are launched on the CLK
//   falling edge, so a rise is registered 2.5 CLK periods later and is visible
//   by the time the period task returns.
module tb_avsdpll_lock_det;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic       REF = 1'b0;
  logic       EN = 1'b1;
  logic       lock_d, ref_lost_d;
  logic [7:0] period_d;
  logic       lock_t, ref_lost_t;
  logic [7:0] period_t;
`ifdef AVSDPLL_LOCKDET_STICKY_EN
  logic       LOL_CLR = 1'b0;
  logic       sticky_d, sticky_t;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  avsdpll_lock_det dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .REF       (REF),
    .EN        (EN),
    .LOCK      (lock_d),
    .REF_LOST  (ref_lost_d),
    .PERIOD_CNT(period_d)
`ifdef AVSDPLL_LOCKDET_STICKY_EN
    ,
    .LOL_STICKY(sticky_d),
    .LOL_CLR   (LOL_CLR)
`endif
  );

  avsdpll_lock_det #(.TOL(1)) dut_tol (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .REF       (REF),
    .EN        (EN),
    .LOCK      (lock_t),
    .REF_LOST  (ref_lost_t),
    .PERIOD_CNT(period_t)
`ifdef AVSDPLL_LOCKDET_STICKY_EN
    ,
    .LOL_STICKY(sticky_t),
    .LOL_CLR   (LOL_CLR)
`endif
  );

  // One REF period of n CLK cycles; called and returns on a CLK falling edge.
  task automatic ref_period(input int n);
    REF = 1'b1;
    repeat (n / 2) @(negedge CLK);
    REF = 1'b0;
    repeat (n - n / 2) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTb = 1'b0;
    repeat (2) @(negedge CLK);
    RSTb = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b0 || period_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_async lock=%b ref_lost=%b period=%0d required 0/0/0", lock_d, ref_lost_d, period_d);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b0 || period_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_clocked lock=%b ref_lost=%b period=%0d required 0/0/0", lock_d, ref_lost_d, period_d);
    end
    RSTb = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_lock_acquire();
    repeat (4) ref_period(8);
    checks++;
    if (lock_d !== 1'b0) begin
      errors++;
      $display("FAIL acq_early_lock lock=%b required 0", lock_d);
    end
    ref_period(8);
    checks++;
    if (lock_d !== 1'b1 || period_d !== 8'd8) begin
      errors++;
      $display("FAIL acq_lock lock=%b period=%0d required 1/8", lock_d, period_d);
    end
    for (int i = 0; i < 20; i++) begin
      ref_period(8);
      checks++;
      if (lock_d !== 1'b1) begin
        errors++;
        $display("FAIL hold_lock period %0d lock=%b required 1", i, lock_d);
      end
    end
    $display("test_lock_acquire done lock=%b period=%0d", lock_d, period_d);
  endtask

  task automatic test_unlock_relock();
    // The rise opening the first 10-cycle period still closes an 8-cycle one.
    repeat (2) ref_period(10);
    checks++;
    if (lock_d !== 1'b1 || period_d !== 8'd10) begin
      errors++;
      $display("FAIL unlock_first_bad lock=%b period=%0d required 1/10", lock_d, period_d);
    end
    ref_period(10);
    checks++;
    if (lock_d !== 1'b0) begin
      errors++;
      $display("FAIL unlock_second_bad lock=%b required 0", lock_d);
    end
    repeat (4) ref_period(8);
    checks++;
    if (lock_d !== 1'b0) begin
      errors++;
      $display("FAIL relock_early lock=%b required 0", lock_d);
    end
    ref_period(8);
    checks++;
    if (lock_d !== 1'b1 || period_d !== 8'd8) begin
      errors++;
      $display("FAIL relock lock=%b period=%0d required 1/8", lock_d, period_d);
    end
    $display("test_unlock_relock done lock=%b", lock_d);
  endtask

  task automatic test_timeout();
    // Last rise registered 5 cycles ago (cnt=5); saturation is 250 edges away.
    repeat (249) @(negedge CLK);
    checks++;
    if (lock_d !== 1'b1 || ref_lost_d !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early lock=%b ref_lost=%b required 1/0", lock_d, ref_lost_d);
    end
    @(negedge CLK);
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b1) begin
      errors++;
      $display("FAIL timeout lock=%b ref_lost=%b required 0/1", lock_d, ref_lost_d);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (ref_lost_d !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold ref_lost=%b required 1", ref_lost_d);
    end
    ref_period(8);
    checks++;
    if (ref_lost_d !== 1'b0 || lock_d !== 1'b0 || period_d !== 8'd255) begin
      errors++;
      $display("FAIL ref_restart ref_lost=%b lock=%b period=%0d required 0/0/255", ref_lost_d, lock_d, period_d);
    end
    repeat (3) ref_period(8);
    checks++;
    if (lock_d !== 1'b0) begin
      errors++;
      $display("FAIL restart_early lock=%b required 0", lock_d);
    end
    ref_period(8);
    checks++;
    if (lock_d !== 1'b1) begin
      errors++;
      $display("FAIL restart_relock lock=%b required 1", lock_d);
    end
    $display("test_timeout done lock=%b", lock_d);
  endtask

  task automatic test_en_and_async_reset();
    EN = 1'b0;
    @(negedge CLK);
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b0 || period_d !== 8'd8) begin
      errors++;
      $display("FAIL en_low lock=%b ref_lost=%b period=%0d required 0/0/8", lock_d, ref_lost_d, period_d);
    end
    repeat (10) @(negedge CLK);
    EN = 1'b1;
    repeat (6) ref_period(8);
    checks++;
    if (lock_d !== 1'b1) begin
      errors++;
      $display("FAIL en_relock lock=%b required 1", lock_d);
    end
    // Assert reset between clock edges and look before any edge arrives.
    #2;
    RSTb = 1'b0;
    #1;
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b0 || period_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_lock lock=%b ref_lost=%b period=%0d required 0/0/0", lock_d, ref_lost_d, period_d);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (2) ref_period(8);
    checks++;
    if (lock_d !== 1'b0 || period_d !== 8'd8) begin
      errors++;
      $display("FAIL acq_pre_reset lock=%b period=%0d required 0/8", lock_d, period_d);
    end
    #2;
    RSTb = 1'b0;
    #1;
    checks++;
    if (lock_d !== 1'b0 || ref_lost_d !== 1'b0 || period_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_acq lock=%b ref_lost=%b period=%0d required 0/0/0", lock_d, ref_lost_d, period_d);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    $display("test_en_and_async_reset done");
  endtask

  task automatic test_tol();
    do_reset();
    for (int i = 0; i < 4; i++) ref_period((i % 2 == 0) ? 7 : 9);
    checks++;
    if (lock_t !== 1'b0) begin
      errors++;
      $display("FAIL tol_early lock=%b required 0", lock_t);
    end
    ref_period(7);
    checks++;
    if (lock_t !== 1'b1 || lock_d !== 1'b0 || period_t !== 8'd9) begin
      errors++;
      $display("FAIL tol_lock tol_lock=%b def_lock=%b period=%0d required 1/0/9", lock_t, lock_d, period_t);
    end
    do_reset();
    for (int i = 0; i < 30; i++) begin
      ref_period(6);
      checks++;
      if (lock_t !== 1'b0 || lock_d !== 1'b0) begin
        errors++;
        $display("FAIL tol_reject period %0d tol_lock=%b def_lock=%b required 0/0", i, lock_t, lock_d);
      end
    end
    checks++;
    if (period_t !== 8'd6) begin
      errors++;
      $display("FAIL tol_reject_period period=%0d required 6", period_t);
    end
    $display("test_tol done tol_lock=%b period=%0d", lock_t, period_t);
  endtask

`ifdef AVSDPLL_LOCKDET_STICKY_EN
  task automatic test_sticky();
    do_reset();
    repeat (5) ref_period(8);
    checks++;
    if (lock_d !== 1'b1 || sticky_d !== 1'b0) begin
      errors++;
      $display("FAIL sticky_locked lock=%b sticky=%b required 1/0", lock_d, sticky_d);
    end
    repeat (3) ref_period(10);
    checks++;
    if (lock_d !== 1'b0 || sticky_d !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set lock=%b sticky=%b required 0/1", lock_d, sticky_d);
    end
    repeat (5) ref_period(8);
    checks++;
    if (lock_d !== 1'b1 || sticky_d !== 1'b1) begin
      errors++;
      $display("FAIL sticky_relock lock=%b sticky=%b required 1/1", lock_d, sticky_d);
    end
    LOL_CLR = 1'b1;
    @(negedge CLK);
    LOL_CLR = 1'b0;
    checks++;
    if (sticky_d !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear sticky=%b required 0", sticky_d);
    end
    // Hold clear across the timeout edge: the set must win on that edge.
    LOL_CLR = 1'b1;
    repeat (249) @(negedge CLK);
    repeat (1) @(negedge CLK);
    LOL_CLR = 1'b0;
    checks++;
    if (lock_d !== 1'b0 || sticky_d !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins lock=%b sticky=%b required 0/1", lock_d, sticky_d);
    end
    EN = 1'b0;
    repeat (2) @(negedge CLK);
    EN = 1'b1;
    checks++;
    if (sticky_d !== 1'b1) begin
      errors++;
      $display("FAIL sticky_en_hold sticky=%b required 1", sticky_d);
    end
    $display("test_sticky done sticky=%b", sticky_d);
  endtask
`endif

  initial begin
    test_reset();
    @(negedge CLK);
    test_lock_acquire();
    test_unlock_relock();
    test_timeout();
    test_en_and_async_reset();
    test_tol();
`ifdef AVSDPLL_LOCKDET_STICKY_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
